// File: rtl/rat_pkg.sv
// Shared helpers for the register alias table.
// Width derivation and per-port slice arithmetic.
package rat_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Never let a derived field collapse to zero bits.
  function automatic int w_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rat_read_port.sv
// One source lookup port of the alias table.
// Retire bypass outranks a pending mapping.
module rat_read_port
  import rat_pkg::*;
#(
  parameter int NUM_AREG = 4,
  parameter int TAG_W    = 2,
  parameter int DATA_W   = 16,
  parameter int AREG_W   = 2
) (
  input  logic [NUM_AREG-1:0]        map_valid,
  input  logic [NUM_AREG*TAG_W-1:0]  map_tag,
  input  logic [NUM_AREG*DATA_W-1:0] arf,
  input  logic                       ret_valid,
  input  logic [AREG_W-1:0]          ret_dst,
  input  logic [TAG_W-1:0]           ret_tag,
  input  logic [DATA_W-1:0]          ret_data,
  input  logic                       req,
  input  logic [AREG_W-1:0]          addr,
  output logic                       tag_valid,
  output logic [TAG_W-1:0]           tag,
  output logic                       val_valid,
  output logic [DATA_W-1:0]          val
);

  logic              hit;
  logic              sel_valid;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_val;
  logic              bypass;

  always_comb begin
    hit       = 1'b0;
    sel_valid = 1'b0;
    sel_tag   = '0;
    sel_val   = '0;
    for (int k = 0; k < NUM_AREG; k++) begin
      if (addr == AREG_W'(k)) begin
        hit       = 1'b1;
        sel_valid = map_valid[k];
        sel_tag   = map_tag[lo(k, TAG_W) +: TAG_W];
        sel_val   = arf[lo(k, DATA_W) +: DATA_W];
      end
    end
  end

  assign bypass = ret_valid && (ret_dst == addr)
               && sel_valid && (sel_tag == ret_tag);

  always_comb begin
    tag_valid = 1'b0;
    tag       = '0;
    val_valid = 1'b0;
    val       = '0;
    priority case (1'b1)
      !req: ;
      !hit: val_valid = 1'b1;
      bypass: begin
        val_valid = 1'b1;
        val       = ret_data;
      end
      sel_valid: begin
        tag_valid = 1'b1;
        tag       = sel_tag;
      end
      default: begin
        val_valid = 1'b1;
        val       = sel_val;
      end
    endcase
  end

endmodule

// File: rtl/rat_multiport.sv
// Register alias table with multiple read ports,
// tag-matched retirement, flush recovery and retire bypass.
module rat_multiport
  import rat_pkg::*;
#(
  parameter int NUM_AREG  = 4,
  parameter int ROB_DEPTH = 4,
  parameter int DATA_W    = 16,
  parameter int NUM_RD    = 2,
  parameter logic [NUM_AREG*DATA_W-1:0] ARF_INIT = '0,
  localparam int TAG_W  = w_of(ROB_DEPTH),
  localparam int AREG_W = w_of(NUM_AREG)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_alloc_valid,
  input  logic [AREG_W-1:0]        i_alloc_dst,
  input  logic [TAG_W-1:0]         i_alloc_tag,
  input  logic                     i_ret_valid,
  input  logic [AREG_W-1:0]        i_ret_dst,
  input  logic [TAG_W-1:0]         i_ret_tag,
  input  logic [DATA_W-1:0]        i_ret_data,
  input  logic                     i_flush,
  input  logic [NUM_RD-1:0]        i_rd_req,
  input  logic [NUM_RD*AREG_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_tag_valid,
  output logic [NUM_RD*TAG_W-1:0]  o_rd_tag,
  output logic [NUM_RD-1:0]        o_rd_val_valid,
  output logic [NUM_RD*DATA_W-1:0] o_rd_val
);

  logic [NUM_AREG-1:0]        map_valid;
  logic [NUM_AREG*TAG_W-1:0]  map_tag;
  logic [NUM_AREG*DATA_W-1:0] arf;

  for (genvar k = 0; k < NUM_AREG; k++) begin : g_reg
    logic              v_q;
    logic [TAG_W-1:0]  t_q;
    logic [DATA_W-1:0] d_q;
    logic              alloc_hit;
    logic              ret_hit;
    logic              ret_clr;

    assign alloc_hit = i_alloc_valid && !i_flush
                    && (i_alloc_dst == AREG_W'(k));
    assign ret_hit   = i_ret_valid && (i_ret_dst == AREG_W'(k));
    // Only the producer still owning the mapping may clear it.
    assign ret_clr   = ret_hit && v_q && (t_q == i_ret_tag);

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        v_q <= 1'b0;
        t_q <= '0;
        d_q <= ARF_INIT[lo(k, DATA_W) +: DATA_W];
      end else begin
        if (i_flush) begin
          v_q <= 1'b0;
        end else if (alloc_hit) begin
          v_q <= 1'b1;
          t_q <= i_alloc_tag;
        end else if (ret_clr) begin
          v_q <= 1'b0;
        end
        if (ret_hit) d_q <= i_ret_data;
      end
    end

    assign map_valid[k]                    = v_q;
    assign map_tag[lo(k, TAG_W) +: TAG_W]  = t_q;
    assign arf[lo(k, DATA_W) +: DATA_W]    = d_q;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rat_read_port #(
      .NUM_AREG (NUM_AREG),
      .TAG_W    (TAG_W),
      .DATA_W   (DATA_W),
      .AREG_W   (AREG_W)
    ) u_port (
      .map_valid (map_valid),
      .map_tag   (map_tag),
      .arf       (arf),
      .ret_valid (i_ret_valid),
      .ret_dst   (i_ret_dst),
      .ret_tag   (i_ret_tag),
      .ret_data  (i_ret_data),
      .req       (i_rd_req[p]),
      .addr      (i_rd_addr[lo(p, AREG_W) +: AREG_W]),
      .tag_valid (o_rd_tag_valid[p]),
      .tag       (o_rd_tag[lo(p, TAG_W) +: TAG_W]),
      .val_valid (o_rd_val_valid[p]),
      .val       (o_rd_val[lo(p, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_rat_multiport.sv
// Bench for rat_multiport: directed walk-through
// followed by randomized traffic against a reference model.
module tb_rat_multiport;

  localparam int NA = 4;
  localparam int DW = 16;
  localparam int NR = 2;
  localparam int TW = 2;
  localparam int AW = 2;
  localparam logic [NA*DW-1:0] INIT = 64'h0009_0006_0003_0005;

  logic i_clk = 1'b0;
  logic i_rstn;
  logic i_alloc_valid;
  logic [AW-1:0] i_alloc_dst;
  logic [TW-1:0] i_alloc_tag;
  logic i_ret_valid;
  logic [AW-1:0] i_ret_dst;
  logic [TW-1:0] i_ret_tag;
  logic [DW-1:0] i_ret_data;
  logic i_flush;
  logic [NR-1:0] i_rd_req;
  logic [NR*AW-1:0] i_rd_addr;
  logic [NR-1:0] o_rd_tag_valid;
  logic [NR*TW-1:0] o_rd_tag;
  logic [NR-1:0] o_rd_val_valid;
  logic [NR*DW-1:0] o_rd_val;

  int n_checks = 0;
  int n_pass = 0;

  // Reference state: pending flag, producer tag, committed value.
  bit pend[NA];
  int owner[NA];
  int regval[NA];

  always #5 i_clk = ~i_clk;

  rat_multiport #(
    .NUM_AREG (NA), .ROB_DEPTH (4), .DATA_W (DW),
    .NUM_RD (NR), .ARF_INIT (INIT)
  ) dut (
    .i_clk (i_clk), .i_rstn (i_rstn),
    .i_alloc_valid (i_alloc_valid), .i_alloc_dst (i_alloc_dst),
    .i_alloc_tag (i_alloc_tag),
    .i_ret_valid (i_ret_valid), .i_ret_dst (i_ret_dst),
    .i_ret_tag (i_ret_tag), .i_ret_data (i_ret_data),
    .i_flush (i_flush), .i_rd_req (i_rd_req), .i_rd_addr (i_rd_addr),
    .o_rd_tag_valid (o_rd_tag_valid), .o_rd_tag (o_rd_tag),
    .o_rd_val_valid (o_rd_val_valid), .o_rd_val (o_rd_val)
  );

  task automatic check(input string tg, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tg, got, exp);
  endtask

  // {tag_valid, tag, val_valid, val}
  function automatic logic [63:0] obs(input int p);
    return {44'b0, o_rd_tag_valid[p], o_rd_tag[p*TW +: TW],
            o_rd_val_valid[p], o_rd_val[p*DW +: DW]};
  endfunction

  function automatic logic [63:0] mk(input bit tv, input int t,
                                     input bit vv, input int v);
    logic [TW-1:0] tt;
    logic [DW-1:0] vd;
    tt = TW'(t);
    vd = DW'(v);
    return {44'b0, tv, tt, vv, vd};
  endfunction

  function automatic logic [63:0] model_rd(input int p);
    int a;
    a = int'(i_rd_addr[p*AW +: AW]);
    if (!i_rd_req[p]) return mk(0, 0, 0, 0);
    if (i_ret_valid && int'(i_ret_dst) == a && pend[a]
        && owner[a] == int'(i_ret_tag))
      return mk(0, 0, 1, int'(i_ret_data));
    if (pend[a]) return mk(1, owner[a], 0, 0);
    return mk(0, 0, 1, regval[a]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin
      pend[k] = 0;
      owner[k] = 0;
      regval[k] = int'(INIT[k*DW +: DW]);
    end
  endtask

  task automatic model_step();
    int rd;
    rd = int'(i_ret_dst);
    if (i_ret_valid) begin
      if (pend[rd] && owner[rd] == int'(i_ret_tag)) pend[rd] = 0;
      regval[rd] = int'(i_ret_data);
    end
    if (i_flush) begin
      for (int k = 0; k < NA; k++) pend[k] = 0;
    end else if (i_alloc_valid) begin
      pend[int'(i_alloc_dst)] = 1;
      owner[int'(i_alloc_dst)] = int'(i_alloc_tag);
    end
  endtask

  task automatic idle();
    i_alloc_valid = 0; i_alloc_dst = 0; i_alloc_tag = 0;
    i_ret_valid = 0; i_ret_dst = 0; i_ret_tag = 0; i_ret_data = 0;
    i_flush = 0; i_rd_req = 0; i_rd_addr = 0;
  endtask

  task automatic rd(input int p, input int a);
    i_rd_req[p] = 1'b1;
    i_rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    idle();
  endtask

  task automatic both_model(input string tg);
    #1;
    check({tg, "_p0"}, obs(0), model_rd(0));
    check({tg, "_p1"}, obs(1), model_rd(1));
  endtask

  initial begin
    idle();
    model_reset();
    i_rstn = 0;
    #12;
    check("rst_p0", obs(0), mk(0, 0, 0, 0));
    i_rstn = 1;
    @(posedge i_clk); #1;

    rd(0, 0); rd(1, 3); #1;
    check("t1_r0", obs(0), mk(0, 0, 1, 5));
    check("t1_r3", obs(1), mk(0, 0, 1, 9));

    i_alloc_valid = 1; i_alloc_dst = 2; i_alloc_tag = 3;
    rd(0, 2); #1;
    check("t2_same", obs(0), mk(0, 0, 1, 6));
    tick();
    rd(0, 2); #1;
    check("t2_next", obs(0), mk(1, 3, 0, 0));

    i_ret_valid = 1; i_ret_dst = 2; i_ret_tag = 3; i_ret_data = 16'h00AA;
    rd(1, 2); #1;
    check("t3_byp", obs(1), mk(0, 0, 1, 'hAA));
    tick();
    rd(1, 2); #1;
    check("t3_arf", obs(1), mk(0, 0, 1, 'hAA));

    i_alloc_valid = 1; i_alloc_dst = 1; i_alloc_tag = 0;
    tick();
    i_alloc_valid = 1; i_alloc_dst = 1; i_alloc_tag = 2;
    tick();
    i_ret_valid = 1; i_ret_dst = 1; i_ret_tag = 0; i_ret_data = 7;
    rd(0, 1); #1;
    check("t4_nobyp", obs(0), mk(1, 2, 0, 0));
    tick();
    rd(0, 1); #1;
    check("t4_young", obs(0), mk(1, 2, 0, 0));

    i_alloc_valid = 1; i_alloc_dst = 0; i_alloc_tag = 1;
    i_ret_valid = 1; i_ret_dst = 0; i_ret_tag = 1; i_ret_data = 4;
    rd(0, 0); #1;
    check("t5_same", obs(0), mk(0, 0, 1, 5));
    tick();
    rd(0, 0); #1;
    check("t5_next", obs(0), mk(1, 1, 0, 0));

    for (int k = 0; k < NA; k++) begin
      i_alloc_valid = 1; i_alloc_dst = AW'(k); i_alloc_tag = TW'(k);
      tick();
    end
    rd(0, 3); #1;
    check("t6_pend", obs(0), mk(1, 3, 0, 0));
    i_flush = 1; i_alloc_valid = 1; i_alloc_dst = 1; i_alloc_tag = 3;
    tick();
    rd(0, 0); rd(1, 1); #1;
    check("t6_r0", obs(0), mk(0, 0, 1, 4));
    check("t6_r1", obs(1), mk(0, 0, 1, 7));
    rd(0, 2); rd(1, 3); #1;
    check("t6_r2", obs(0), mk(0, 0, 1, 'hAA));
    check("t6_r3", obs(1), mk(0, 0, 1, 9));
    i_rd_req = 0; #1;
    check("noreq", obs(0), mk(0, 0, 0, 0));

    i_alloc_valid = 1; i_alloc_dst = 2; i_alloc_tag = 1;
    tick();
    #2;
    i_rstn = 0;
    model_reset();
    rd(0, 1); rd(1, 2); #1;
    check("rst_r1", obs(0), mk(0, 0, 1, 3));
    check("rst_r2", obs(1), mk(0, 0, 1, 6));
    rd(0, 0); rd(1, 3); #1;
    check("rst_r0", obs(0), mk(0, 0, 1, 5));
    check("rst_r3", obs(1), mk(0, 0, 1, 9));
    @(negedge i_clk);
    i_rstn = 1;
    @(posedge i_clk); #1;
    idle();

    for (int c = 0; c < 400; c++) begin
      int d;
      i_alloc_valid = ($urandom_range(0, 1) == 1);
      i_alloc_dst = AW'($urandom_range(0, NA - 1));
      i_alloc_tag = TW'($urandom_range(0, 3));
      i_ret_valid = ($urandom_range(0, 2) != 0);
      d = int'($urandom_range(0, NA - 1));
      i_ret_dst = AW'(d);
      if ($urandom_range(0, 9) < 7) i_ret_tag = TW'(owner[d]);
      else i_ret_tag = TW'($urandom_range(0, 3));
      i_ret_data = DW'($urandom);
      i_flush = ($urandom_range(0, 15) == 0);
      i_rd_req = NR'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) i_rd_req = '1;
      i_rd_addr = (NR * AW)'($urandom);
      if ($urandom_range(0, 1) == 1)
        i_rd_addr[0 +: AW] = AW'(d);
      both_model("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
